// File: rtl/data_mem_responder.sv
// Variable-latency single-word data memory responder with a start/done handshake.
// Optional random extra wait states (0..3) are enabled with `DMEM_RANDOM_LATENCY_EN.
module data_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic        done,
    output logic        busy
);

`ifdef DMEM_RANDOM_LATENCY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [31:0]            q_q;
    logic                   accept;
    logic                   commit;
    logic                   unused_addr_hi;
    logic [31:0]            mem [0:(1<<ADDR_BITS)-1];

    assign unused_addr_hi = ^addr[31:ADDR_BITS];
    assign accept         = start && (state_q != WAIT);

`ifdef DMEM_RANDOM_LATENCY_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign wait_cnt = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign wait_cnt = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE, RESP: begin
                if (start) begin
                    we_d    = we;
                    addr_d  = addr[ADDR_BITS-1:0];
                    data_d  = data;
                    cnt_d   = wait_cnt;
                    state_d = (wait_cnt != '0) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT);
        done_d = (state_d == RESP);
    end

    // The _d request fields always describe the request being committed on RESP entry.
    assign commit = (state_d == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (commit) begin
            if (we_d) begin
                mem[addr_d] <= data_d;
            end else begin
                q_q <= mem[addr_d];
            end
        end
    end

    assign q    = q_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; one DUT instance per latency under test.
// Random-latency checks run when DMEM_RANDOM_LATENCY_EN is defined, directed latency checks otherwise.
module tb_data_mem_responder;

    localparam int N = 5;
    // Instance latencies, index 0..4: 2, 0, 3, 4, 1
    localparam logic [19:0] LATS = {4'd1, 4'd4, 4'd3, 4'd0, 4'd2};

    logic        clk = 1'b0;
    logic        rst_s   [N];
    logic        start_s [N];
    logic        we_s    [N];
    logic        done_s  [N];
    logic        busy_s  [N];
    logic [31:0] addr_s  [N];
    logic [31:0] data_s  [N];
    logic [31:0] q_s     [N];

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_BITS(10),
            .LATENCY  (int'(LATS[g*4 +: 4]))
        ) u_dut (
            .clk  (clk),
            .reset(rst_s[g]),
            .start(start_s[g]),
            .we   (we_s[g]),
            .addr (addr_s[g]),
            .data (data_s[g]),
            .q    (q_s[g]),
            .done (done_s[g]),
            .busy (busy_s[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        start_s[i] = 1'b1;
        we_s[i]    = w;
        addr_s[i]  = a;
        data_s[i]  = d;
        tick();
        start_s[i] = 1'b0;
    endtask

    // Issues one request and returns in its done cycle; gap = cycles from start to done.
    task automatic request(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int gap, output int busy_cnt);
        applyStimulus(i, w, a, d);
        gap      = 1;
        busy_cnt = 0;
        while (done_s[i] !== 1'b1 && gap < 40) begin
            if (busy_s[i] === 1'b1) busy_cnt++;
            tick();
            gap++;
        end
    endtask

    task automatic doWrite(input int i, input logic [31:0] a, input logic [31:0] d);
        int g, b;
        request(i, 1'b1, a, d, g, b);
        tick();
    endtask

    task automatic countDone(input int i, input int cycles, output int dcount, output logic [31:0] qcap);
        dcount = 0;
        qcap   = '0;
        for (int k = 0; k < cycles; k++) begin
            if (done_s[i] === 1'b1) begin
                dcount++;
                qcap = q_s[i];
            end
            tick();
        end
    endtask

    initial begin
        int          gap, bc, dcount;
        logic [31:0] qcap;

        for (int i = 0; i < N; i++) begin
            rst_s[i]   = 1'b1;
            start_s[i] = 1'b0;
            we_s[i]    = 1'b0;
            addr_s[i]  = '0;
            data_s[i]  = '0;
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            checkOutput("reset_done", 32'(done_s[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy_s[i]), 32'd0);
            checkOutput("reset_q", q_s[i], 32'd0);
        end

`ifndef DMEM_RANDOM_LATENCY_EN
        // LATENCY=2: write then read back
        request(0, 1'b1, 32'd5, 32'hDEADBEEF, gap, bc);
        checkOutput("l2_wr_gap", 32'(gap), 32'd3);
        checkOutput("l2_wr_busy_cycles", 32'(bc), 32'd2);
        checkOutput("l2_wr_q_unchanged", q_s[0], 32'd0);
        tick();
        checkOutput("l2_done_one_cycle", 32'(done_s[0]), 32'd0);
        request(0, 1'b0, 32'd5, 32'd0, gap, bc);
        checkOutput("l2_rd_gap", 32'(gap), 32'd3);
        checkOutput("l2_rd_busy_cycles", 32'(bc), 32'd2);
        checkOutput("l2_rd_q", q_s[0], 32'hDEADBEEF);
        tick();

        // Upper address bits are ignored
        doWrite(0, 32'hFFFF_FC0A, 32'hCAFEF00D);
        request(0, 1'b0, 32'h0000_000A, 32'd0, gap, bc);
        checkOutput("alias_q", q_s[0], 32'hCAFEF00D);
        tick();
        checkOutput("q_holds_after_read", q_s[0], 32'hCAFEF00D);

        // LATENCY=0: back-to-back reads
        request(1, 1'b1, 32'd1, 32'h0101_0101, gap, bc);
        checkOutput("l0_wr_gap", 32'(gap), 32'd1);
        checkOutput("l0_wr_busy_cycles", 32'(bc), 32'd0);
        tick();
        doWrite(1, 32'd2, 32'h0202_0202);
        doWrite(1, 32'd3, 32'h0303_0303);
        start_s[1] = 1'b1;
        we_s[1]    = 1'b0;
        addr_s[1]  = 32'd1;
        tick();
        checkOutput("b2b_done1", 32'(done_s[1]), 32'd1);
        checkOutput("b2b_q1", q_s[1], 32'h0101_0101);
        checkOutput("b2b_busy1", 32'(busy_s[1]), 32'd0);
        addr_s[1] = 32'd2;
        tick();
        checkOutput("b2b_done2", 32'(done_s[1]), 32'd1);
        checkOutput("b2b_q2", q_s[1], 32'h0202_0202);
        checkOutput("b2b_busy2", 32'(busy_s[1]), 32'd0);
        addr_s[1] = 32'd3;
        tick();
        checkOutput("b2b_done3", 32'(done_s[1]), 32'd1);
        checkOutput("b2b_q3", q_s[1], 32'h0303_0303);
        start_s[1] = 1'b0;
        tick();
        checkOutput("b2b_idle_done", 32'(done_s[1]), 32'd0);

        // Read issued in the RESP cycle of a write to the same word
        start_s[1] = 1'b1;
        we_s[1]    = 1'b1;
        addr_s[1]  = 32'd4;
        data_s[1]  = 32'h4444_4444;
        tick();
        checkOutput("raw_wr_done", 32'(done_s[1]), 32'd1);
        we_s[1] = 1'b0;
        tick();
        start_s[1] = 1'b0;
        checkOutput("raw_rd_done", 32'(done_s[1]), 32'd1);
        checkOutput("raw_rd_q", q_s[1], 32'h4444_4444);
        tick();

        // LATENCY=3: start during WAIT is ignored
        doWrite(2, 32'd0, 32'h0000_C0DE);
        doWrite(2, 32'd7, 32'h7777_0000);
        applyStimulus(2, 1'b0, 32'd0, 32'd0);
        checkOutput("l3_busy", 32'(busy_s[2]), 32'd1);
        start_s[2] = 1'b1;
        we_s[2]    = 1'b1;
        addr_s[2]  = 32'd7;
        data_s[2]  = 32'h0000_1234;
        tick();
        start_s[2] = 1'b0;
        countDone(2, 8, dcount, qcap);
        checkOutput("l3_done_count", 32'(dcount), 32'd1);
        checkOutput("l3_rd_q", qcap, 32'h0000_C0DE);
        request(2, 1'b0, 32'd7, 32'd0, gap, bc);
        checkOutput("l3_ignored_write", q_s[2], 32'h7777_0000);
        tick();

        // LATENCY=4: reset drops an in-flight write; start with reset is ignored
        doWrite(3, 32'd9, 32'h9999_9999);
        request(3, 1'b0, 32'd9, 32'd0, gap, bc);
        checkOutput("l4_pre_q", q_s[3], 32'h9999_9999);
        tick();
        applyStimulus(3, 1'b1, 32'd9, 32'hAAAA5555);
        tick();
        rst_s[3]   = 1'b1;
        start_s[3] = 1'b1;
        we_s[3]    = 1'b0;
        tick();
        rst_s[3]   = 1'b0;
        start_s[3] = 1'b0;
        checkOutput("l4_rst_busy", 32'(busy_s[3]), 32'd0);
        checkOutput("l4_rst_done", 32'(done_s[3]), 32'd0);
        checkOutput("l4_rst_q", q_s[3], 32'd0);
        countDone(3, 10, dcount, qcap);
        checkOutput("l4_no_done", 32'(dcount), 32'd0);
        request(3, 1'b0, 32'd9, 32'd0, gap, bc);
        checkOutput("l4_rd_gap", 32'(gap), 32'd5);
        checkOutput("l4_write_dropped", q_s[3], 32'h9999_9999);
        tick();
`else
        begin
            int         gaps [200];
            logic [3:0] seen = '0;
            for (int r = 0; r < 200; r++) begin
                request(4, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, gap, bc);
                gaps[r] = gap;
                checkOutput("rand_gap_range", 32'(gap >= 2 && gap <= 5), 32'd1);
                if (gap >= 2 && gap <= 5) seen[gap-2] = 1'b1;
                tick();
            end
            checkOutput("rand_all_w_seen", 32'(seen), 32'hF);
            rst_s[4] = 1'b1;
            tick();
            tick();
            rst_s[4] = 1'b0;
            for (int r = 0; r < 20; r++) begin
                request(4, 1'b0, 32'(r), 32'd0, gap, bc);
                checkOutput("rand_repeat_after_reset", 32'(gap), 32'(gaps[r]));
                tick();
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
